mem_cpu_bus_initiator: RTL and testbench
========================================

// Module: mem_cpu_bus_initiator
// PURPOSE
//  CPU-side initiator for local memory bus cycles served by the memory block (MEM top level).
//  Accepts one read/write/fetch request from the CPU core, arbitrates with CRQ_n/CGNT_n and drives LBD address/data.
//  Waits for BDRY_n, returns read data plus parity status, and signals out-of-range (MOR_n) on timeout.
//  Sits between the CPU micro-sequencer and the MEM_43 local bus pins.
// PARAMETERS
//  TIMEOUT_CYCLES  64  sysclk cycles from CRQ_n assertion to BDRY_n before MOR abort (>=4)
//  ADDR_CYCLES     1   cycles LBD holds address before data phase (1..3)
// PORTS
//  sysclk          in   1   single system clock; all logic rising-edge
//  sys_rst         in   1   asynchronous, active-high reset
//  req_valid       in   1   CPU request present
//  req_ready       out  1   initiator idle, request accepted when valid&ready
//  req_write       in   1   1=write, 0=read
//  req_fetch       in   1   read is instruction fetch (drives FETCH)
//  req_addr        in   24  physical address (PPN:offset)
//  req_wdata       in   16  write data
//  rsp_valid       out  1   one-cycle completion strobe
//  rsp_rdata       out  16  read data, valid with rsp_valid
//  rsp_err         out  2   00 ok, 01 parity (LPERR_n), 10 timeout/MOR, 11 unused
//  CRQ_n           out  1   CPU bus request, active low
//  CGNT_n          in   1   CPU bus grant from memory arbiter, active low
//  LBD_23_0_OUT    out  24  local bus address/data drive
//  LBD_OE          out  1   1 = LBD_23_0_OUT driven
//  LBD_15_0_IN     in   16  local bus read data
//  WRITE           out  1   cycle direction, stable from ADDR to DONE
//  FETCH           out  1   fetch qualifier, stable from ADDR to DONE
//  BDRY_n          in   1   memory data ready, active low
//  LPERR_n         in   1   memory parity error, active low, sampled with BDRY_n
//  MOR_n           out  1   memory out of range, one-cycle low pulse on timeout
// BEHAVIOUR
//  Reset (async, immediate): state IDLE; req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=00, CRQ_n=1,
//   LBD_OE=0, LBD_23_0_OUT=0, WRITE=0, FETCH=0, MOR_n=1, timer=0. Reset mid-cycle releases bus same instant.
//  States: IDLE -> REQ -> ADDR -> DATA -> DONE -> IDLE; any of REQ/ADDR/DATA -> ABORT -> IDLE.
//  IDLE: req_ready=1; on req_valid latch addr/wdata/write/fetch, CRQ_n<=0, timer cleared, -> REQ.
//  REQ: req_ready=0; wait sampled CGNT_n==0 -> ADDR (grant seen earliest 1 cycle after CRQ_n low).
//  ADDR: LBD_OE=1, LBD=addr, WRITE/FETCH valid; after ADDR_CYCLES cycles -> DATA.
//  DATA: write: LBD[15:0]=wdata, [23:16]=0, OE=1; read: OE=0. Wait sampled BDRY_n==0.
//   On BDRY_n low: read captures LBD_15_0_IN; err=01 if read and LPERR_n==0 (writes ignore LPERR_n) -> DONE.
//  DONE: rsp_valid=1 one cycle; CRQ_n=1, OE=0, WRITE/FETCH=0 -> IDLE. CRQ_n high >=1 cycle between cycles.
//  Timer: counts every cycle in REQ/ADDR/DATA; at TIMEOUT_CYCLES-1 -> ABORT.
//  ABORT: MOR_n=0 one cycle, rsp_valid=1, rsp_rdata=0, rsp_err=10, bus released -> IDLE.
//  Simultaneous BDRY_n low and timeout terminal count: BDRY wins, normal DONE, MOR_n stays 1.
//  CGNT_n rising during ADDR/DATA ignored; grant considered held until CRQ_n released.
//  BDRY_n low while in REQ/ADDR ignored (stale ready from other master).
//  req_valid while busy: not accepted; held by CPU until req_ready.
//  rsp_rdata/rsp_err hold last value until next completion.
//  Latency: read with immediate grant and BDRY = 1(REQ)+ADDR_CYCLES+1(DATA)+1(DONE) cycles from accept.
// STRUCTURE
//  Shared constants header mem_bus_defs: state encodings, RSP_OK/RSP_PERR/RSP_MOR codes.
//  One sub-module: mem_bus_timeout_timer (clear, enable, terminal-count out, width from TIMEOUT_CYCLES).
//  Remaining FSM, latches and bus drivers in this module; no tristates, OE exported to top-level mux.
// TESTING
//  Read: addr=0x012345, CGNT_n low next cycle, BDRY_n low 3 cycles later, LBD_IN=0xBEEF -> rsp_rdata=0xBEEF, err=00.
//  Write: addr=0x000100 wdata=0xA5A5 -> LBD shows 0x000100 for ADDR_CYCLES then 0x00A5A5, WRITE=1 until DONE.
//  Parity: read with LPERR_n=0 at BDRY_n -> err=01, data still captured; write with LPERR_n=0 -> err=00.
//  Timeout: CGNT_n never low -> MOR_n low exactly one cycle at cycle 64 after accept, err=10, CRQ_n=1 after.
//  Race: BDRY_n low on cycle 63 terminal count -> err=00, MOR_n never low; back-to-back requests show CRQ_n high 1 cycle.
//  Reset: assert sys_rst during DATA -> CRQ_n=1, LBD_OE=0, req_ready=1 without a clock edge.

Source files
------------

// File: rtl/mem_bus_defs_pkg.sv
// Shared definitions for the CPU-side local memory bus initiator:
// FSM state encodings, completion status codes and a state-class helper.
package mem_bus_defs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ADDR,
    ST_DATA,
    ST_DONE,
    ST_ABORT
  } state_e;

  localparam logic [1:0] RSP_OK   = 2'b00;
  localparam logic [1:0] RSP_PERR = 2'b01;
  localparam logic [1:0] RSP_MOR  = 2'b10;

  // True while the initiator holds CRQ_n low and the cycle timer runs.
  function automatic logic bus_owned(input state_e s);
    return (s == ST_REQ) || (s == ST_ADDR) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/mem_bus_timeout_timer.sv
// Cycle timer for one bus transaction: cleared on request accept, counts while
// enabled, flags the terminal count TIMEOUT_CYCLES-1.
module mem_bus_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic sysclk,
  input  logic sys_rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);

  localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] TC_VAL = W'(TIMEOUT_CYCLES - 1);
  localparam logic [W-1:0] ONE    = W'(1);

  logic [W-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst)       count_q <= '0;
    else if (clear_i)  count_q <= '0;
    else if (enable_i) count_q <= count_q + ONE;
  end

  assign tc_o = (count_q == TC_VAL);

endmodule

// File: rtl/mem_cpu_bus_initiator.sv
// CPU-side local bus initiator: arbitrates with CRQ_n/CGNT_n, drives address
// then data on LBD, waits for BDRY_n and reports data, parity or MOR timeout.
module mem_cpu_bus_initiator
  import mem_bus_defs_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ADDR_CYCLES    = 1
) (
  input  logic        sysclk,
  input  logic        sys_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_fetch,
  input  logic [23:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic        CRQ_n,
  input  logic        CGNT_n,
  output logic [23:0] LBD_23_0_OUT,
  output logic        LBD_OE,
  input  logic [15:0] LBD_15_0_IN,
  output logic        WRITE,
  output logic        FETCH,
  input  logic        BDRY_n,
  input  logic        LPERR_n,
  output logic        MOR_n
);

  localparam logic [1:0] ADDR_LAST = 2'(ADDR_CYCLES - 1);

  state_e      state_q, state_d;
  logic [23:0] addr_q;
  logic [15:0] wdata_q;
  logic        write_q, fetch_q;
  logic [1:0]  acnt_q;
  logic [15:0] rdata_q, rdata_d;
  logic [1:0]  err_q, err_d;
  logic        accept, tc;

  mem_bus_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .sysclk   (sysclk),
    .sys_rst  (sys_rst),
    .clear_i  (accept),
    .enable_i (bus_owned(state_q)),
    .tc_o     (tc)
  );

  // NOTE: every always_comb output is defaulted first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: if (req_valid) begin
        accept  = 1'b1;
        state_d = ST_REQ;
      end
      ST_REQ:  if (tc) state_d = ST_ABORT;
               else if (!CGNT_n) state_d = ST_ADDR;
      ST_ADDR: if (tc) state_d = ST_ABORT;
               else if (acnt_q == ADDR_LAST) state_d = ST_DATA;
      // BDRY_n is checked before the terminal count so a ready on the last cycle completes normally.
      ST_DATA: if (!BDRY_n) begin
        state_d = ST_DONE;
        err_d   = (!write_q && !LPERR_n) ? RSP_PERR : RSP_OK;
        if (!write_q) rdata_d = LBD_15_0_IN;
      end else if (tc) begin
        state_d = ST_ABORT;
      end
      ST_DONE, ST_ABORT: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_ABORT) begin
      rdata_d = '0;
      err_d   = RSP_MOR;
    end
  end

  // NOTE: datapath latches are reset too, so bus outputs are defined from the first cycle.
  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      fetch_q <= 1'b0;
      acnt_q  <= '0;
      rdata_q <= '0;
      err_q   <= RSP_OK;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      acnt_q  <= (state_q == ST_ADDR) ? acnt_q + 2'd1 : 2'd0;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        write_q <= req_write;
        fetch_q <= req_fetch;
      end
    end
  end

  always_comb begin
    LBD_23_0_OUT = '0;
    if (state_q == ST_ADDR)                 LBD_23_0_OUT = addr_q;
    else if (state_q == ST_DATA && write_q) LBD_23_0_OUT = {8'h00, wdata_q};
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_DONE) || (state_q == ST_ABORT);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign CRQ_n     = !bus_owned(state_q);
  assign LBD_OE    = (state_q == ST_ADDR) || (state_q == ST_DATA && write_q);
  assign WRITE     = write_q && ((state_q == ST_ADDR) || (state_q == ST_DATA));
  assign FETCH     = fetch_q && ((state_q == ST_ADDR) || (state_q == ST_DATA));
  assign MOR_n     = (state_q != ST_ABORT);

endmodule

// File: tb/tb_mem_cpu_bus_initiator.sv
// Directed self-checking bench for mem_cpu_bus_initiator (TIMEOUT_CYCLES=64, ADDR_CYCLES=1).
module tb_mem_cpu_bus_initiator;

  logic        sysclk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, req_fetch = 1'b0;
  logic [23:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        req_ready, rsp_valid;
  logic [15:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        CRQ_n, CGNT_n = 1'b1;
  logic [23:0] LBD_23_0_OUT;
  logic        LBD_OE;
  logic [15:0] LBD_15_0_IN = '0;
  logic        WRITE, FETCH;
  logic        BDRY_n = 1'b1, LPERR_n = 1'b1;
  logic        MOR_n;

  int n_checks = 0;
  int n_errors = 0;

  mem_cpu_bus_initiator #(.TIMEOUT_CYCLES(64), .ADDR_CYCLES(1)) dut (
    .sysclk(sysclk), .sys_rst(sys_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_fetch(req_fetch), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .CRQ_n(CRQ_n), .CGNT_n(CGNT_n),
    .LBD_23_0_OUT(LBD_23_0_OUT), .LBD_OE(LBD_OE), .LBD_15_0_IN(LBD_15_0_IN),
    .WRITE(WRITE), .FETCH(FETCH), .BDRY_n(BDRY_n), .LPERR_n(LPERR_n), .MOR_n(MOR_n)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic fe, input logic [23:0] a, input logic [15:0] d);
    req_valid = 1'b1;
    req_write = wr;
    req_fetch = fe;
    req_addr  = a;
    req_wdata = d;
  endtask

  int first_mor, mor_cnt;

  initial begin
    #1;
    check("rst_ready", req_ready, 1);
    check("rst_crq", CRQ_n, 1);
    check("rst_oe", LBD_OE, 0);
    check("rst_lbd", LBD_23_0_OUT, 0);
    check("rst_rvalid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_err", rsp_err, 0);
    check("rst_mor", MOR_n, 1);
    check("rst_wr_fe", {WRITE, FETCH}, 0);
    tick();
    sys_rst = 1'b0;
    tick();

    // Read with one idle DATA cycle before BDRY_n.
    issue(1'b0, 1'b1, 24'h012345, 16'h0);
    tick();
    req_valid = 1'b0;
    check("rd_req_crq", CRQ_n, 0);
    check("rd_req_ready", req_ready, 0);
    check("rd_req_oe", LBD_OE, 0);
    CGNT_n = 1'b0;
    tick();
    check("rd_addr_oe", LBD_OE, 1);
    check("rd_addr_lbd", LBD_23_0_OUT, 24'h012345);
    check("rd_addr_wf", {WRITE, FETCH}, 2'b01);
    CGNT_n = 1'b1;
    tick();
    check("rd_data_oe", LBD_OE, 0);
    check("rd_data_crq", CRQ_n, 0);
    tick();
    check("rd_wait_rvalid", rsp_valid, 0);
    BDRY_n = 1'b0;
    LBD_15_0_IN = 16'hBEEF;
    tick();
    BDRY_n = 1'b1;
    check("rd_done_rvalid", rsp_valid, 1);
    check("rd_done_rdata", rsp_rdata, 16'hBEEF);
    check("rd_done_err", rsp_err, 0);
    check("rd_done_crq", CRQ_n, 1);
    check("rd_done_fetch", FETCH, 0);
    tick();
    check("rd_idle_rvalid", rsp_valid, 0);
    check("rd_idle_ready", req_ready, 1);
    check("rd_hold_rdata", rsp_rdata, 16'hBEEF);

    // Write, immediate grant; BDRY_n already low in REQ/ADDR must be ignored; LPERR_n ignored on write.
    CGNT_n = 1'b0;
    BDRY_n = 1'b0;
    LPERR_n = 1'b0;
    issue(1'b1, 1'b0, 24'h000100, 16'hA5A5);
    tick();
    req_valid = 1'b0;
    check("wr_req_crq", CRQ_n, 0);
    check("wr_req_rvalid", rsp_valid, 0);
    tick();
    check("wr_addr_lbd", LBD_23_0_OUT, 24'h000100);
    check("wr_addr_oe", LBD_OE, 1);
    check("wr_addr_write", WRITE, 1);
    tick();
    check("wr_data_lbd", LBD_23_0_OUT, 24'h00A5A5);
    check("wr_data_oe", LBD_OE, 1);
    check("wr_data_write", WRITE, 1);
    check("wr_data_rvalid", rsp_valid, 0);
    issue(1'b0, 1'b0, 24'h00ABCD, 16'h0);
    LBD_15_0_IN = 16'h1234;
    tick();
    check("wr_done_rvalid", rsp_valid, 1);
    check("wr_done_err", rsp_err, 0);
    check("wr_done_write", WRITE, 0);
    check("wr_done_oe", LBD_OE, 0);
    check("wr_done_crq", CRQ_n, 1);
    check("b2b_busy_ready", req_ready, 0);

    // Back-to-back parity read: CRQ_n high through DONE and IDLE, then low again.
    tick();
    check("b2b_idle_crq", CRQ_n, 1);
    check("b2b_idle_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    check("b2b_req_crq", CRQ_n, 0);
    tick();
    check("pe_addr_lbd", LBD_23_0_OUT, 24'h00ABCD);
    tick();
    tick();
    check("pe_done_rvalid", rsp_valid, 1);
    check("pe_done_err", rsp_err, 2'b01);
    check("pe_done_rdata", rsp_rdata, 16'h1234);
    CGNT_n = 1'b1;
    BDRY_n = 1'b1;
    LPERR_n = 1'b1;
    tick();

    // Timeout: no grant ever; MOR_n must pulse on cycle 64 after accept, once.
    issue(1'b0, 1'b0, 24'h7FFFFF, 16'h0);
    tick();
    req_valid = 1'b0;
    first_mor = 0;
    mor_cnt = 0;
    for (int k = 1; k <= 70; k++) begin
      tick();
      if (!MOR_n) begin
        mor_cnt++;
        if (first_mor == 0) begin
          first_mor = k;
          check("to_rvalid", rsp_valid, 1);
          check("to_err", rsp_err, 2'b10);
          check("to_rdata", rsp_rdata, 0);
        end
      end
      if (k == first_mor + 1 && first_mor != 0) check("to_after_crq", CRQ_n, 1);
    end
    check("to_cycle", first_mor, 64);
    check("to_pulse_len", mor_cnt, 1);

    // Race: BDRY_n low exactly on the terminal-count cycle wins over the timeout.
    CGNT_n = 1'b0;
    LBD_15_0_IN = 16'h5A5A;
    issue(1'b0, 1'b0, 24'h000200, 16'h0);
    tick();
    req_valid = 1'b0;
    mor_cnt = 0;
    for (int k = 1; k <= 63; k++) begin
      tick();
      if (!MOR_n) mor_cnt++;
    end
    check("race_pre_rvalid", rsp_valid, 0);
    BDRY_n = 1'b0;
    tick();
    BDRY_n = 1'b1;
    check("race_rvalid", rsp_valid, 1);
    check("race_err", rsp_err, 0);
    check("race_rdata", rsp_rdata, 16'h5A5A);
    if (!MOR_n) mor_cnt++;
    tick();
    if (!MOR_n) mor_cnt++;
    check("race_no_mor", mor_cnt, 0);

    // Asynchronous reset during DATA releases the bus without a clock edge.
    issue(1'b1, 1'b0, 24'h000300, 16'h1111);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check("ar_pre_oe", LBD_OE, 1);
    #2;
    sys_rst = 1'b1;
    #1;
    check("ar_crq", CRQ_n, 1);
    check("ar_oe", LBD_OE, 0);
    check("ar_ready", req_ready, 1);
    check("ar_rdata", rsp_rdata, 0);
    tick();
    sys_rst = 1'b0;
    CGNT_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
